iomem_dma_initiator: RTL and testbench

//  Bus-master (initiator) end of the PicoSoC iomem valid/ready interface. Copies a block of
//  32-bit words from a source to a destination address, one word at a time, as a read beat

---
 rtl/iomem_dma_initiator_if.sv | 13 +
 rtl/iomem_dma_initiator.sv | 180 ++++++++++++++++++
 tb/tb_iomem_dma_initiator.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/iomem_dma_initiator_if.sv
// PicoSoC iomem valid/ready bus between a DMA initiator and its responders.
// Requests stay up until ready; the responder answers with a single-cycle ready strobe.
interface iomem_dma_initiator_if;
  logic        valid;
  logic        ready;
  logic [3:0]  wstrb;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (output valid, wstrb, addr, wdata, input ready, rdata);
  modport slave  (input valid, wstrb, addr, wdata, output ready, rdata);
endinterface

// File: rtl/iomem_dma_initiator.sv
// Word-copy DMA master on the iomem bus: one read beat then one write beat per word.
// Latency: bus request the cycle after start, 6 cycles/word with 1-cycle ready; waits on ready with an optional per-beat timeout.
module iomem_dma_initiator #(
  parameter int LEN_BITS = 16,
  parameter int TIMEOUT  = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cfg_start,
  input  logic                  cfg_abort,
  input  logic [31:0]           cfg_src,
  input  logic [31:0]           cfg_dst,
  input  logic [LEN_BITS-1:0]   cfg_len,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [LEN_BITS-1:0]   words_done,
  iomem_dma_initiator_if.master iomem
);

  localparam int TW      = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam int TO_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

  typedef enum logic [2:0] {
    S_IDLE, S_RD, S_RD_GAP, S_WR, S_WR_GAP, S_FIN
  } state_t;

  state_t              state, state_n;
  logic [31:0]         src_q, src_n;
  logic [31:0]         dst_q, dst_n;
  logic [LEN_BITS-1:0] len_q, len_n;
  logic [LEN_BITS-1:0] wd_q, wd_n;
  logic [31:0]         addr_q, addr_n;
  logic [31:0]         wdata_q, wdata_n;
  logic                err_q, err_n;
  logic                abort_q, abort_n;
  logic [TW-1:0]       to_cnt, to_n;
  logic                valid_q, busy_q, done_q;
  logic [3:0]          wstrb_q;

  logic beat_done;
  logic to_hit;
  logic abort_any;

  assign beat_done = valid_q & iomem.ready;
  // Ready in the final allowed cycle still completes the beat; timeout only fires without it.
  assign to_hit    = (TIMEOUT != 0) && valid_q && !iomem.ready && (to_cnt == TW'(TO_LAST));
  assign abort_any = abort_q | cfg_abort;

  always_comb begin
    state_n = state;
    src_n   = src_q;
    dst_n   = dst_q;
    len_n   = len_q;
    wd_n    = wd_q;
    addr_n  = addr_q;
    wdata_n = wdata_q;
    err_n   = err_q;
    abort_n = abort_q;
    to_n    = to_cnt;

    if (cfg_abort && state != S_IDLE && state != S_FIN) begin
      abort_n = 1'b1;
    end

    unique case (state)
      S_IDLE: begin
        if (cfg_start) begin
          src_n   = {cfg_src[31:2], 2'b00};
          dst_n   = {cfg_dst[31:2], 2'b00};
          len_n   = cfg_len;
          wd_n    = '0;
          err_n   = 1'b0;
          abort_n = 1'b0;
          if (cfg_len != '0) begin
            state_n = S_RD;
            addr_n  = {cfg_src[31:2], 2'b00};
            to_n    = '0;
          end else begin
            state_n = S_FIN;
          end
        end
      end
      S_RD: begin
        if (beat_done) begin
          wdata_n = iomem.rdata;
          state_n = S_RD_GAP;
        end else if (to_hit) begin
          err_n   = 1'b1;
          state_n = S_FIN;
        end else begin
          to_n = to_cnt + TW'(1);
        end
      end
      S_RD_GAP: begin
        if (abort_any) begin
          state_n = S_FIN;
        end else begin
          state_n = S_WR;
          addr_n  = dst_q;
          to_n    = '0;
        end
      end
      S_WR: begin
        if (beat_done) begin
          wd_n    = wd_q + LEN_BITS'(1);
          src_n   = src_q + 32'd4;
          dst_n   = dst_q + 32'd4;
          state_n = S_WR_GAP;
        end else if (to_hit) begin
          err_n   = 1'b1;
          state_n = S_FIN;
        end else begin
          to_n = to_cnt + TW'(1);
        end
      end
      S_WR_GAP: begin
        if (wd_q == len_q || abort_any) begin
          state_n = S_FIN;
        end else begin
          state_n = S_RD;
          addr_n  = src_q;
          to_n    = '0;
        end
      end
      S_FIN: begin
        state_n = S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  // Bus and status outputs are registered from the next state so they change together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      len_q   <= '0;
      wd_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
      abort_q <= 1'b0;
      to_cnt  <= '0;
      valid_q <= 1'b0;
      wstrb_q <= 4'h0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state   <= state_n;
      src_q   <= src_n;
      dst_q   <= dst_n;
      len_q   <= len_n;
      wd_q    <= wd_n;
      addr_q  <= addr_n;
      wdata_q <= wdata_n;
      err_q   <= err_n;
      abort_q <= abort_n;
      to_cnt  <= to_n;
      valid_q <= (state_n == S_RD) || (state_n == S_WR);
      wstrb_q <= (state_n == S_WR) ? 4'hF : 4'h0;
      busy_q  <= (state_n == S_RD) || (state_n == S_RD_GAP) ||
                 (state_n == S_WR) || (state_n == S_WR_GAP);
      done_q  <= (state_n == S_FIN);
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign error       = err_q;
  assign words_done  = wd_q;
  assign iomem.valid = valid_q;
  assign iomem.wstrb = wstrb_q;
  assign iomem.addr  = addr_q;
  assign iomem.wdata = wdata_q;

endmodule

// File: tb/tb_iomem_dma_initiator.sv
// Directed bench for iomem_dma_initiator against a latency-programmable iomem responder.
module tb_iomem_dma_initiator;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cfg_start = 1'b0;
  logic        cfg_abort = 1'b0;
  logic [31:0] cfg_src = '0;
  logic [31:0] cfg_dst = '0;
  logic [15:0] cfg_len = '0;
  logic        busy, done, error;
  logic [15:0] words_done;

  int vecs  = 0;
  int fails = 0;
  int lat   = 1;

  always #5 clk = ~clk;

  iomem_dma_initiator_if iomem();

  iomem_dma_initiator #(.LEN_BITS(16), .TIMEOUT(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .cfg_start  (cfg_start),
    .cfg_abort  (cfg_abort),
    .cfg_src    (cfg_src),
    .cfg_dst    (cfg_dst),
    .cfg_len    (cfg_len),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .words_done (words_done),
    .iomem      (iomem)
  );

  // Source memory contents; gpio[0] sits at 0x0300_0000.
  function automatic logic [31:0] peek(input logic [31:0] a);
    if (a == 32'h0300_0000) return 32'hA5A5_0001;
    return a ^ 32'h5A5A_C3C3;
  endfunction

  logic [31:0] q_addr[$];
  logic [31:0] q_data[$];
  logic [3:0]  q_strb[$];
  int          wcnt;

  // Registered-ready responder: ready pulses 'lat' cycles after a request appears (lat=0: never).
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      iomem.ready <= 1'b0;
      iomem.rdata <= '0;
      wcnt        <= 0;
    end else begin
      if (iomem.valid && iomem.ready) begin
        q_addr.push_back(iomem.addr);
        q_strb.push_back(iomem.wstrb);
        q_data.push_back(iomem.wstrb != 4'h0 ? iomem.wdata : iomem.rdata);
      end
      if (iomem.valid && !iomem.ready && lat != 0 && wcnt + 1 >= lat) begin
        iomem.ready <= 1'b1;
        iomem.rdata <= peek(iomem.addr);
        wcnt        <= 0;
      end else begin
        iomem.ready <= 1'b0;
        wcnt        <= (iomem.valid && !iomem.ready) ? wcnt + 1 : 0;
      end
    end
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    vecs++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] src;
    logic [31:0] dst;
    int          len;
    int          lat;
    int          abort_wr;
    bit          restart;
    int          exp_words;
    bit          exp_err;
    int          exp_beats;
    int          exp_cycles;
    int          exp_run;
  } vec_t;

  task automatic run_vec(input int id, input vec_t v);
    logic [31:0] s, d;
    logic [31:0] expd[$];
    logic [31:0] pa, pw, pd;
    logic [3:0]  ps;
    logic        pv, pr;
    int dt, dones, ddt, run, maxrun, qbase, nw;
    s = v.src & 32'hFFFF_FFFC;
    d = v.dst & 32'hFFFF_FFFC;
    for (int k = 0; k < v.exp_words; k++) expd.push_back(peek(s + 32'(4 * k)));
    qbase = q_addr.size();
    lat   = v.lat;

    @(negedge clk);
    cfg_src   = v.src;
    cfg_dst   = v.dst;
    cfg_len   = 16'(v.len);
    cfg_start = 1'b1;
    @(negedge clk);
    cfg_start = 1'b0;
    chk($sformatf("v%0d_first_busy", id), busy, v.len != 0);
    chk($sformatf("v%0d_first_valid", id), iomem.valid, v.len != 0);
    chk($sformatf("v%0d_first_err", id), error, 1'b0);
    if (v.len != 0) chk($sformatf("v%0d_first_addr", id), {iomem.addr, iomem.wstrb}, {s, 4'h0});

    dt = 1; dones = 0; ddt = -1; run = 0; maxrun = 0;
    pv = 1'b0; pr = 1'b0; pa = '0; pw = '0; pd = '0; ps = '0;
    forever begin
      if (done) begin
        dones++;
        if (ddt < 0) ddt = dt;
        cfg_abort = 1'b0;
      end
      if (iomem.valid) begin
        run++;
        if (run > maxrun) maxrun = run;
      end else begin
        run = 0;
      end
      if (pv && !pr && iomem.valid)
        chk($sformatf("v%0d_hold_dt%0d", id, dt), {iomem.addr, iomem.wstrb, iomem.wdata}, {pa, ps, pd});
      if (pv && pr)
        chk($sformatf("v%0d_gap_dt%0d", id, dt), iomem.valid, 1'b0);
      pv = iomem.valid; pr = iomem.ready; pa = iomem.addr; ps = iomem.wstrb; pd = iomem.wdata;
      if (ddt >= 0 && dt >= ddt + 8) break;
      if (dt >= 3000) begin
        vecs++; fails++;
        $display("FAIL v%0d_timeout: no done within %0d cycles", id, dt);
        break;
      end
      nw = 0;
      for (int k = qbase; k < q_strb.size(); k++) if (q_strb[k] == 4'hF) nw++;
      if (v.abort_wr > 0 && iomem.valid && iomem.wstrb == 4'hF && nw == v.abort_wr - 1) cfg_abort = 1'b1;
      cfg_start = v.restart && (dt == 3);
      @(negedge clk);
      dt++;
    end
    cfg_start = 1'b0;
    cfg_abort = 1'b0;
    pw = '0;

    chk($sformatf("v%0d_done_count", id), dones, 1);
    chk($sformatf("v%0d_done_cycle", id), ddt, v.exp_cycles);
    chk($sformatf("v%0d_words_done", id), words_done, 16'(v.exp_words));
    chk($sformatf("v%0d_error", id), error, v.exp_err);
    chk($sformatf("v%0d_idle_busy", id), busy, 1'b0);
    chk($sformatf("v%0d_valid_run", id), maxrun, v.exp_run);
    chk($sformatf("v%0d_beats", id), q_addr.size() - qbase, v.exp_beats);
    if (q_addr.size() - qbase == v.exp_beats) begin
      for (int k = 0; k < v.exp_beats; k++) begin
        if (k % 2 == 0)
          chk($sformatf("v%0d_rd%0d", id, k / 2), {q_addr[qbase + k], q_strb[qbase + k], q_data[qbase + k]},
              {s + 32'(4 * (k / 2)), 4'h0, expd[k / 2]});
        else
          chk($sformatf("v%0d_wr%0d", id, k / 2), {q_addr[qbase + k], q_strb[qbase + k], q_data[qbase + k]},
              {d + 32'(4 * (k / 2)), 4'hF, expd[k / 2]});
      end
    end
  endtask

  vec_t vt[7];
  vec_t vr;

  initial begin
    //          src            dst            len lat abt rst words err beats cyc run
    vt[0] = '{32'h0300_0000, 32'h0300_0004,   1,  1,  0,  0,  1,   0,  2,    7,  2};
    vt[1] = '{32'h0300_0010, 32'h0300_0020,   0,  1,  0,  0,  0,   0,  0,    1,  0};
    vt[2] = '{32'h0300_0102, 32'h0300_0203,   4,  3,  0,  0,  4,   0,  8,   41,  4};
    vt[3] = '{32'h0300_0300, 32'h0300_0380,   2,  7,  0,  0,  2,   0,  4,   37,  8};
    vt[4] = '{32'h0300_0600, 32'h0300_0700,   3,  0,  0,  0,  0,   1,  0,    9,  8};
    vt[5] = '{32'h0300_0800, 32'h0300_0900, 100,  1,  3,  0,  3,   0,  6,   19,  2};
    vt[6] = '{32'hFFFF_FFFC, 32'h0000_2000,   2,  1,  0,  0,  2,   0,  4,   13,  2};
    vr    = '{32'h0300_0A00, 32'h0300_0B00,   2,  1,  0,  1,  2,   0,  4,   13,  2};

    repeat (2) @(negedge clk);
    chk("reset_outputs", {busy, done, error, words_done, iomem.valid, iomem.wstrb, iomem.addr, iomem.wdata}, '0);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_after_reset", {busy, done, iomem.valid}, 3'b000);

    for (int i = 0; i < 7; i++) run_vec(i, vt[i]);

    // Reset while a write beat is waiting for ready.
    lat = 3;
    cfg_src = 32'h0300_0400; cfg_dst = 32'h0300_0500; cfg_len = 16'd3; cfg_start = 1'b1;
    @(negedge clk);
    cfg_start = 1'b0;
    for (int c = 0; c < 200 && !(iomem.valid && iomem.wstrb == 4'hF); c++) @(negedge clk);
    chk("wr_beat_reached", {iomem.valid, iomem.wstrb}, {1'b1, 4'hF});
    reset = 1'b1;
    #1;
    chk("reset_midbeat_valid", iomem.valid, 1'b0);
    chk("reset_midbeat_busy", busy, 1'b0);
    chk("reset_midbeat_bus", {iomem.wstrb, iomem.addr, iomem.wdata, words_done}, '0);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    run_vec(7, vr);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end

endmodule
